// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiplier and
// restoring divider, one iteration per clock, with a start/busy/done handshake.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [CW-1:0]          cnt_r;
    logic [2*WIDTH-1:0]     acc_r;
    logic [WIDTH-1:0]       opd_r;
    logic [WIDTH-1:0]       dividend_r;
    logic                   div_r;
    logic                   neg_q_r;
    logic                   neg_r_r;
    logic                   div0_r;

    logic                   start_arith_s;
    logic                   load_s;
    logic                   iter_s;
    logic                   fin_s;
    logic                   mthi_s;
    logic                   mtlo_s;
    logic [WIDTH:0]         add_s;
    logic [WIDTH:0]         rem_sh_s;
    logic [WIDTH-1:0]       diff_s;
    logic [2*WIDTH-1:0]     mul_next_s;
    logic [2*WIDTH-1:0]     div_next_s;
    logic [WIDTH-1:0]       res_hi_s;
    logic [WIDTH-1:0]       res_lo_s;
    logic [2*WIDTH-1:0]     prod_s;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? negate(v) : v;
    endfunction

    assign start_arith_s = start && !op[2];

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_arith_s) state_next_s = RUN;
                else               state_next_s = IDLE;
            end
            RUN: begin
                if (cnt_r == CW'(WIDTH - 1)) state_next_s = FINISH;
                else                         state_next_s = RUN;
            end
            FINISH:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM control decode; HI/LO moves are only honoured while idle
    always_comb begin
        load_s = 1'b0;
        iter_s = 1'b0;
        fin_s  = 1'b0;
        mthi_s = 1'b0;
        mtlo_s = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = start_arith_s;
                mthi_s = start && (op == 3'b100);
                mtlo_s = start && (op == 3'b101);
            end
            RUN:     iter_s = 1'b1;
            FINISH:  fin_s  = 1'b1;
            default: load_s = 1'b0;
        endcase
    end

    // One multiply (shift-add) and one divide (restoring) iteration step
    always_comb begin
        add_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opd_r};
        mul_next_s = acc_r[0] ? {add_s, acc_r[WIDTH-1:1]} : {1'b0, acc_r[2*WIDTH-1:1]};
        rem_sh_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        diff_s     = rem_sh_s[WIDTH-1:0] - opd_r;
        if (rem_sh_s >= {1'b0, opd_r}) begin
            div_next_s = {diff_s, acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero override of the final result
    always_comb begin
        prod_s = neg_q_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;
        if (!div_r) begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else if (div0_r) begin
            res_hi_s = dividend_r;
            res_lo_s = {WIDTH{1'b1}};
        end else begin
            res_hi_s = neg_r_r ? negate(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
            res_lo_s = neg_q_r ? negate(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        end
    end

    // Operand latch and iteration datapath (acc = {rem,quo} or running product)
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r      <= '0;
            opd_r      <= '0;
            dividend_r <= '0;
            cnt_r      <= '0;
            div_r      <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div0_r     <= 1'b0;
        end else if (load_s) begin
            cnt_r      <= '0;
            div_r      <= op[1];
            neg_q_r    <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r    <= !op[0] && a[WIDTH-1];
            div0_r     <= op[1] && (b == '0);
            dividend_r <= a;
            if (op[1]) begin
                acc_r <= {{WIDTH{1'b0}}, magnitude(a, !op[0])};
                opd_r <= magnitude(b, !op[0]);
            end else begin
                acc_r <= {{WIDTH{1'b0}}, magnitude(b, !op[0])};
                opd_r <= magnitude(a, !op[0]);
            end
        end else if (iter_s) begin
            acc_r <= div_r ? div_next_s : mul_next_s;
            cnt_r <= cnt_r + CW'(1);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Architectural HI/LO and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next_s != IDLE);
            done <= fin_s;
            if (fin_s) begin
                hi <= res_hi_s;
                lo <= res_lo_s;
            end else if (mthi_s) begin
                hi <= a;
            end else if (mtlo_s) begin
                lo <= a;
            end else begin
                hi <= hi;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue an op at the current negedge and wait (bounded) for done; ends on the done negedge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output bit got);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) lat++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hFFFF_0000; b = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0; start = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
        end
    endtask

    task automatic test_mult();
        int lat; bit got;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, got);
        checks++;
        if (!got || lat !== 33) begin
            errors++;
            $display("FAIL mult_latency: got_done=%0d busy_cycles=%0d, required 1 33", got, lat);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            errors++;
            $display("FAIL mult_result: hi=%h lo=%h, required ffffffff fffffff1", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_multu();
        int changed = 0; bit got = 0;
        start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) changed++;
                @(negedge clk);
            end
        end
        checks++;
        if (changed !== 0) begin
            errors++;
            $display("FAIL multu_hold: hi/lo changed in %0d busy cycles, required 0", changed);
        end
        checks++;
        if (!got || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_result: done=%0d hi=%h lo=%h, required 1 fffffffe 00000001", got, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        int lat; bit got;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, got);
        checks++;
        if (!got || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_neg: done=%0d lo=%h hi=%h, required 1 fffffffd ffffffff", got, lo, hi);
        end
        @(negedge clk);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, got);
        checks++;
        if (!got || lo !== 32'h8000_0000 || hi !== 32'd0) begin
            errors++;
            $display("FAIL div_overflow: done=%0d lo=%h hi=%h, required 1 80000000 00000000", got, lo, hi);
        end
        @(negedge clk);
    endtask

    task automatic test_div_by_zero();
        int lat; bit got;
        run_op(OP_DIVU, 32'd100, 32'd0, lat, got);
        checks++;
        if (!got || lat !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h0000_0064) begin
            errors++;
            $display("FAIL divu_zero: done=%0d lat=%0d lo=%h hi=%h, required 1 33 ffffffff 00000064",
                     got, lat, lo, hi);
        end
        @(negedge clk);
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd0, lat, got);
        checks++;
        if (!got || lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FF9C) begin
            errors++;
            $display("FAIL div_zero_signed: done=%0d lo=%h hi=%h, required 1 ffffffff ffffff9c", got, lo, hi);
        end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        int bd = 0;
        start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
        @(negedge clk);
        if (busy || done) bd++;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h, required 12345678 ffffffff", hi, lo);
        end
        op = OP_MTLO; a = 32'h9ABC_DEF0;
        @(negedge clk);
        start = 1'b0;
        if (busy || done) bd++;
        checks++;
        if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h, required 12345678 9abcdef0", hi, lo);
        end
        op = 3'b110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy || done) bd++;
        checks++;
        if (bd !== 0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL move_no_handshake: busy/done seen %0d times hi=%h lo=%h, required 0 12345678 9abcdef0",
                     bd, hi, lo);
        end
    endtask

    task automatic test_mthi_during_mult();
        bit got = 0;
        start = 1'b1; op = OP_MULT; a = 32'h0001_0000; b = 32'h0001_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (hi !== 32'h1234_5678 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mthi_while_busy: hi=%h busy=%b, required 12345678 1", hi, busy);
        end
        for (int i = 0; i < 100 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!got || hi !== 32'h0000_0001 || lo !== 32'h0000_0000) begin
            errors++;
            $display("FAIL mult_after_ignored_mthi: done=%0d hi=%h lo=%h, required 1 00000001 00000000", got, hi, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int lat; bit got;
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== {1'b0, 1'b0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
        end
        run_op(OP_MULT, 32'd6, 32'd7, lat, got);
        checks++;
        if (!got || lat !== 33 || lo !== 32'd42 || hi !== 32'd0) begin
            errors++;
            $display("FAIL mult_after_reset: done=%0d lat=%0d lo=%h hi=%h, required 1 33 0000002a 00000000",
                     got, lat, lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit got;
        run_op(OP_DIVU, 32'd100, 32'd7, lat, got);
        checks++;
        if (!got || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL b2b_first: done=%0d lo=%h hi=%h, required 1 0000000e 00000002", got, lo, hi);
        end
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, got);
        checks++;
        if (!got || lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
            errors++;
            $display("FAIL b2b_second: done=%0d lat=%0d lo=%h hi=%h, required 1 33 fffffffd 00000001",
                     got, lat, lo, hi);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; a = 32'd0; b = 32'd0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_by_zero();
        test_mthi_mtlo();
        test_mthi_during_mult();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core. It replaces the single-cycle combinational product/quotient path with a parametrised multi-cycle engine: a shift-add multiplier and a restoring divider, driven by a start/busy/done handshake. The core stalls on busy before MFHI/MFLO. The unit sits beside the ALU in the execute stage, and hi/lo feed the MFHI/MFLO result mux.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count per MULT/DIV op equals WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x ignored
a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high while an arithmetic op is in flight
done  output  1  one-cycle pulse when hi/lo take an arithmetic result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset, sampled at a clk edge while reset=1: hi=0, lo=0, busy=0, done=0, FSM=IDLE. Reset overrides start. Reset mid-operation aborts the op; hi/lo go to 0, not partial results.
- FSM states: IDLE, RUN, FINISH.
- IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}, at edge E0:
  - Latch operands: magnitudes for signed ops, raw values for unsigned ops.
  - Record the result signs.
  - Clear the iteration counter.
  - Go to RUN; busy=1 from E0.
- IDLE with start=1 and op=MTHI/MTLO: hi (or lo) <= a at E0. Other register unchanged. No busy, no done. FSM stays IDLE.
- IDLE with start=1 and op=11x: no effect.
- RUN: one iteration per edge, E1..E_WIDTH.
  - Multiply: 2·WIDTH-bit accumulator, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - Counter reaches WIDTH-1 -> FINISH.
- FINISH, at edge E_(WIDTH+1):
  - Apply sign correction.
  - Write hi/lo; done=1 for exactly the following cycle; busy=0 from the same edge.
  - Go to IDLE.
  - Result therefore appears WIDTH+1 cycles after the start edge.
- Result mapping:
  - MULT/MULTU: {hi, lo} = full 2·WIDTH-bit product. Signed product is negated iff the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (b=0, either signedness): lo = all ones, hi = a (unmodified dividend). Uses the normal WIDTH+1 latency; no exception.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0. This falls out of the magnitude arithmetic.
- start while busy=1: ignored regardless of op, including MTHI/MTLO. Operands and in-flight op are unaffected. The core must hold its request until busy=0.
- hi/lo are stable throughout RUN and change only at FINISH, MTHI/MTLO, or reset.
- start in the cycle done=1 is accepted normally, so back-to-back ops are allowed.
- a and b are sampled only at E0; changes during RUN have no effect.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=5 -> busy for 33 cycles, done pulse once, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; hi/lo hold prior values until the done cycle.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 33 cycles.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi/lo updated the next cycle, busy and done never asserted. MTHI issued during a MULT -> ignored; MULT result is written.
- Assert reset at the 10th RUN cycle of a DIVU -> next cycle busy=0, done=0, hi=lo=0. A new MULT 6×7 then yields lo=42, hi=0.
